// File: rtl/peripheral_muldiv.sv
// Memory-mapped unsigned multiply/divide peripheral: shift-add multiply and
// restoring divide, one step per clock, W steps per operation.
module peripheral_muldiv #(
  parameter int unsigned W = 16
) (
  input  logic           clock,
  input  logic           rst,
  input  logic [W-1:0]   d_in,
  input  logic           cs,
  input  logic [4:0]     addr,
  input  logic           rd,
  input  logic           wr,
  output logic [2*W-1:0] d_out
);

  localparam int unsigned CntW = $clog2(W);

  localparam logic [4:0] AddrA      = 5'h04;
  localparam logic [4:0] AddrB      = 5'h08;
  localparam logic [4:0] AddrCtrl   = 5'h0C;
  localparam logic [4:0] AddrResLo  = 5'h10;
  localparam logic [4:0] AddrStatus = 5'h14;
  localparam logic [4:0] AddrResHi  = 5'h18;

  typedef enum logic [1:0] {StIdle, StRun, StDone} state_e;

  state_e state_q, state_d;

  logic [W-1:0]   a_q, b_q;
  logic           mode_q;
  logic           div_zero_q;
  logic [CntW-1:0] cnt_q;
  // Multiply: mcand shifts left, mplier shifts right, acc accumulates.
  // Divide: mplier holds dividend/quotient, mcand[W-1:0] divisor, acc partial remainder.
  logic [2*W-1:0] mcand_q;
  logic [W-1:0]   mplier_q;
  logic [2*W-1:0] acc_q;
  logic [2*W-1:0] res_lo_q;
  logic [W-1:0]   res_hi_q;

  logic           wr_en, rd_en, start, start_ok, start_div0, last_step;
  logic           busy, done;
  logic [2*W-1:0] acc_mul;
  logic [W:0]     rem_sh, rem_new;
  logic           div_ge;
  logic [W-1:0]   quo_new;
  logic [2*W-1:0] rd_data;

  // Write wins over read when both strobes are high.
  assign wr_en      = cs & wr;
  assign rd_en      = cs & rd & ~wr;
  assign start      = wr_en && (addr == AddrCtrl) && d_in[0];
  assign start_ok   = start && (state_q != StRun);
  assign start_div0 = d_in[1] && (b_q == '0);
  assign last_step  = (cnt_q == CntW'(W - 1));

  // State register
  always_ff @(posedge clock or posedge rst) begin
    if (rst) begin
      state_q <= StIdle;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state logic
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      StIdle, StDone: begin
        if (start_ok) begin
          state_d = start_div0 ? StDone : StRun;
        end
      end
      StRun: begin
        if (last_step) begin
          state_d = StDone;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  // State-decoded outputs
  always_comb begin
    busy = 1'b0;
    done = 1'b0;
    unique case (state_q)
      StRun:   busy = 1'b1;
      StDone:  done = 1'b1;
      default: ;
    endcase
  end

  // One arithmetic step
  always_comb begin
    acc_mul = mplier_q[0] ? (acc_q + mcand_q) : acc_q;
    rem_sh  = {acc_q[W-1:0], mplier_q[W-1]};
    div_ge  = (rem_sh >= {1'b0, mcand_q[W-1:0]});
    rem_new = div_ge ? (rem_sh - {1'b0, mcand_q[W-1:0]}) : rem_sh;
    quo_new = {mplier_q[W-2:0], div_ge};
  end

  always_comb begin
    rd_data = '0;
    unique case (addr)
      AddrA:      rd_data = {{W{1'b0}}, a_q};
      AddrB:      rd_data = {{W{1'b0}}, b_q};
      AddrResLo:  rd_data = res_lo_q;
      AddrStatus: rd_data = {{(2*W-3){1'b0}}, div_zero_q, busy, done};
      AddrResHi:  rd_data = {{W{1'b0}}, res_hi_q};
      default:    rd_data = '0;
    endcase
  end

  always_ff @(posedge clock or posedge rst) begin
    if (rst) begin
      a_q        <= '0;
      b_q        <= '0;
      mode_q     <= 1'b0;
      div_zero_q <= 1'b0;
      cnt_q      <= '0;
      mcand_q    <= '0;
      mplier_q   <= '0;
      acc_q      <= '0;
      res_lo_q   <= '0;
      res_hi_q   <= '0;
      d_out      <= '0;
    end else begin
      if (wr_en && (state_q != StRun)) begin
        if (addr == AddrA) a_q <= d_in;
        if (addr == AddrB) b_q <= d_in;
      end

      if (start_ok) begin
        mode_q     <= d_in[1];
        div_zero_q <= start_div0;
        cnt_q      <= '0;
        acc_q      <= '0;
        mplier_q   <= d_in[1] ? a_q : b_q;
        mcand_q    <= {{W{1'b0}}, (d_in[1] ? b_q : a_q)};
        if (start_div0) begin
          res_lo_q <= '1;
          res_hi_q <= a_q;
        end
      end else if (state_q == StRun) begin
        cnt_q <= cnt_q + 1'b1;
        if (mode_q) begin
          acc_q    <= {{(W-1){1'b0}}, rem_new};
          mplier_q <= quo_new;
        end else begin
          acc_q    <= acc_mul;
          mplier_q <= mplier_q >> 1;
          mcand_q  <= mcand_q << 1;
        end
        if (last_step) begin
          res_lo_q <= mode_q ? {{W{1'b0}}, quo_new} : acc_mul;
          res_hi_q <= mode_q ? rem_new[W-1:0] : '0;
        end
      end

      if (rd_en) begin
        d_out <= rd_data;
      end
    end
  end

endmodule

// File: tb/tb_peripheral_muldiv.sv
// Scoreboard bench for peripheral_muldiv (W=16): reads push expected data,
// a monitor compares d_out on the falling edge after each sampled read.
module tb_peripheral_muldiv;

  localparam int unsigned W = 16;

  localparam logic [4:0] AddrA      = 5'h04;
  localparam logic [4:0] AddrB      = 5'h08;
  localparam logic [4:0] AddrCtrl   = 5'h0C;
  localparam logic [4:0] AddrResLo  = 5'h10;
  localparam logic [4:0] AddrStatus = 5'h14;
  localparam logic [4:0] AddrResHi  = 5'h18;

  logic           clock = 1'b0;
  logic           rst   = 1'b1;
  logic [W-1:0]   d_in  = '0;
  logic           cs    = 1'b0;
  logic [4:0]     addr  = '0;
  logic           rd    = 1'b0;
  logic           wr    = 1'b0;
  logic [2*W-1:0] d_out;

  typedef struct {
    string          name;
    logic [2*W-1:0] exp;
  } sb_t;

  sb_t sb[$];
  int  n_cmp  = 0;
  int  n_fail = 0;

  peripheral_muldiv #(.W(W)) dut (
    .clock(clock),
    .rst  (rst),
    .d_in (d_in),
    .cs   (cs),
    .addr (addr),
    .rd   (rd),
    .wr   (wr),
    .d_out(d_out)
  );

  always #5 clock = ~clock;

  // Monitor: a read sampled on a rising edge is checked on the next falling edge.
  initial begin
    logic fire;
    sb_t  e;
    forever begin
      @(posedge clock);
      fire = cs && rd && !wr;
      if (fire) begin
        @(negedge clock);
        n_cmp++;
        if (sb.size() == 0) begin
          n_fail++;
          $display("FAIL unexpected_read: d_out=0x%08h with no expected entry", d_out);
        end else begin
          e = sb.pop_front();
          if (d_out !== e.exp) begin
            n_fail++;
            $display("FAIL %s: d_out=0x%08h expected 0x%08h", e.name, d_out, e.exp);
          end
        end
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit expired");
    $fatal(1, "watchdog expired");
  end

  task automatic bus(input logic c, input logic w, input logic r, input logic [4:0] a,
                     input logic [W-1:0] d);
    @(negedge clock);
    cs = c; wr = w; rd = r; addr = a; d_in = d;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) bus(1'b0, 1'b0, 1'b0, 5'h00, '0);
  endtask

  task automatic write(input logic [4:0] a, input logic [W-1:0] d);
    bus(1'b1, 1'b1, 1'b0, a, d);
  endtask

  task automatic read(input string name, input logic [4:0] a, input logic [2*W-1:0] exp);
    sb.push_back('{name, exp});
    bus(1'b1, 1'b0, 1'b1, a, '0);
  endtask

  // Full operation: start lands on edge N, waits through N+W+1.
  task automatic op(input logic [W-1:0] a, input logic [W-1:0] b, input logic [W-1:0] ctrl);
    write(AddrA, a);
    write(AddrB, b);
    write(AddrCtrl, ctrl);
    idle(W + 1);
  endtask

  initial begin
    idle(2);
    @(negedge clock);
    rst = 1'b0;

    read("rst_status", AddrStatus, 32'h0);
    read("rst_res_lo", AddrResLo,  32'h0);
    read("rst_res_hi", AddrResHi,  32'h0);
    read("rst_a",      AddrA,      32'h0);

    // Multiply 0x5B*0xC with exact completion timing
    write(AddrA, 16'h005B);
    write(AddrB, 16'h000C);
    write(AddrCtrl, 16'h0001);
    idle(15);
    read("mul_busy_n16", AddrStatus, 32'h2);
    read("mul_done_n17", AddrStatus, 32'h1);
    read("mul_res_lo",   AddrResLo,  32'h0000_0444);
    read("mul_res_hi",   AddrResHi,  32'h0);

    op(16'h0444, 16'h000C, 16'h0003);
    read("div_status", AddrStatus, 32'h1);
    read("div_res_lo", AddrResLo,  32'h0000_005B);
    read("div_res_hi", AddrResHi,  32'h0);

    op(16'd100, 16'd7, 16'h0003);
    read("div100_lo", AddrResLo, 32'd14);
    read("div100_hi", AddrResHi, 32'd2);

    op(16'hFFFF, 16'hFFFF, 16'h0001);
    read("mulmax_lo", AddrResLo, 32'hFFFE_0001);
    read("mulmax_hi", AddrResHi, 32'h0);

    op(16'hFFFF, 16'h0001, 16'h0003);
    read("divmax_lo", AddrResLo, 32'h0000_FFFF);
    read("divmax_hi", AddrResHi, 32'h0);

    // rd+wr is a write; cs=0 write ignored; DONE-state writes keep results
    bus(1'b1, 1'b1, 1'b1, AddrA, 16'h0777);
    read("rdwr_is_write", AddrA, 32'h0000_0777);
    bus(1'b0, 1'b1, 1'b0, AddrA, 16'h9999);
    read("cs_low_ignored", AddrA, 32'h0000_0777);
    read("done_res_kept",  AddrResLo, 32'h0000_FFFF);

    // Divide by zero resolves in one edge
    write(AddrA, 16'h0025);
    write(AddrB, 16'h0000);
    write(AddrCtrl, 16'h0003);
    read("dz_status", AddrStatus, 32'h5);
    read("dz_res_lo", AddrResLo,  32'hFFFF_FFFF);
    read("dz_res_hi", AddrResHi,  32'h0000_0025);

    read("ctrl_reads_0", AddrCtrl, 32'h0);
    read("unmapped_0",   5'h1C,    32'h0);

    // Writes to B and a second start while busy are ignored
    write(AddrA, 16'h005B);
    write(AddrB, 16'h000C);
    write(AddrCtrl, 16'h0001);
    idle(4);
    write(AddrB, 16'h0003);
    write(AddrCtrl, 16'h0001);
    idle(9);
    read("busy_wr_n16",   AddrStatus, 32'h2);
    read("busy_wr_n17",   AddrStatus, 32'h1);
    read("busy_wr_res",   AddrResLo,  32'h0000_0444);
    read("busy_wr_b_old", AddrB,      32'h0000_000C);

    // Reset mid-run
    write(AddrA, 16'h005B);
    write(AddrB, 16'h000C);
    write(AddrCtrl, 16'h0001);
    idle(7);
    @(negedge clock);
    rst = 1'b1;
    read("rst_mid_dout", AddrStatus, 32'h0);
    @(negedge clock);
    rst = 1'b0;
    cs  = 1'b0;
    rd  = 1'b0;
    read("rst_mid_status", AddrStatus, 32'h0);
    read("rst_mid_res_lo", AddrResLo,  32'h0);
    read("rst_mid_b",      AddrB,      32'h0);
    op(16'd100, 16'd7, 16'h0003);
    read("post_rst_status", AddrStatus, 32'h1);
    read("post_rst_lo",     AddrResLo,  32'd14);
    read("post_rst_hi",     AddrResHi,  32'd2);

    idle(3);
    n_cmp++;
    if (sb.size() != 0) begin
      n_fail++;
      $display("FAIL sb_drain: %0d entries left, required 0", sb.size());
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
